btn_cnt: RTL

BTN_CNT -- requirements
Module: btn_cnt

---
 rtl/btn_cnt.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/btn_cnt.sv
// btn_cnt -- 4-digit BCD up/down counter driven by push-button pulses,
// with an optional auto-count mode stepping once every DIV clock cycles.
//
// Parameters
//   DIV   CLK cycles per auto-count step (legal 2 .. 2**26).
//
// Ports
//   CLK   input   1   system clock, everything on posedge CLK
//   nRST  input   1   synchronous, active-low reset
//   BIN   input   3   debounced one-cycle press pulses, active-high:
//                     [0]=inc, [1]=dec, [2]=run/stop toggle
//   CNT   output  16  packed BCD count, [15:12] thousands .. [3:0] units
//   RUN   output  1   1 while in the auto-count state (mirrors the FSM state)
//   DIR   output  1   auto-count direction, 0 = up, 1 = down
//   WRAP  output  1   one-cycle pulse after a step wrapped 9999<->0000
//
// Input protocol: BIN carries no handshake and no backpressure. Every cycle
// in which a bit is high is one event; a bit held high for N cycles is N
// events. A step caused in cycle t is visible on CNT in cycle t+1.
module btn_cnt #(
  parameter int DIV = 50000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [2:0]  BIN,
  output logic [15:0] CNT,
  output logic        RUN,
  output logic        DIR,
  output logic        WRAP
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            wrap_q, wrap_d;

  logic            inc, dec, clr, tick;

  // BCD increment: a digit at 9 rolls to 0 and carries into the next digit.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement: a digit at 0 rolls to 9 and borrows from the next digit.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign inc  = BIN[0] & ~BIN[1];
  assign dec  = BIN[1] & ~BIN[0];
  assign clr  = BIN[0] &  BIN[1];
  assign tick = (state_q == ST_RUN) && (pre_q == PRE_MAX);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;

    if (BIN[2]) begin
      state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end

    // Prescaler holds at 0 in STOP and restarts on every toggle, so the
    // first auto step lands exactly DIV cycles after the toggle is sampled.
    if (state_q != ST_RUN || BIN[2] || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    // Manual actions take priority; a tick coinciding with any manual
    // action or with a toggle is dropped.
    if (clr) begin
      cnt_d = 16'h0000;
    end else if (inc) begin
      cnt_d  = bcd_inc(cnt_q);
      dir_d  = 1'b0;
      wrap_d = (cnt_q == 16'h9999);
    end else if (dec) begin
      cnt_d  = bcd_dec(cnt_q);
      dir_d  = 1'b1;
      wrap_d = (cnt_q == 16'h0000);
    end else if (tick && !BIN[2]) begin
      if (dir_q) begin
        cnt_d  = bcd_dec(cnt_q);
        wrap_d = (cnt_q == 16'h0000);
      end else begin
        cnt_d  = bcd_inc(cnt_q);
        wrap_d = (cnt_q == 16'h9999);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_STOP;
      pre_q   <= '0;
      cnt_q   <= 16'h0000;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign CNT  = cnt_q;
  assign RUN  = (state_q == ST_RUN);
  assign DIR  = dir_q;
  assign WRAP = wrap_q;

endmodule
